// File: rtl/multi_mode_counter.sv
// multi_mode_counter: WIDTH-bit sequencer/counter with EVEN, ODD, ALL and
// PINGPONG modes, up/down direction, a runtime inclusive upper limit, a
// synchronous load and a registered wrap/reversal pulse. All outputs are
// registered; next-value arithmetic is carried in WIDTH+1 bits so overflow
// and underflow are visible rather than truncated.
module multi_mode_counter #(
    parameter int unsigned       WIDTH   = 4,
    parameter logic [WIDTH-1:0]  RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] cnt,
    output logic             wrap,
    output logic             cfg_err
);

    localparam logic [1:0] MODE_EVEN = 2'd0;
    localparam logic [1:0] MODE_ODD  = 2'd1;
    localparam logic [1:0] MODE_ALL  = 2'd2;
    localparam logic [1:0] MODE_PP   = 2'd3;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam logic [WIDTH:0] ONE_X = {{WIDTH{1'b0}}, 1'b1};
    localparam logic [WIDTH:0] TWO_X = {{(WIDTH-1){1'b0}}, 2'b10};

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             cfg_err_q, cfg_err_d;
    logic             dir_q, dir_d;

    logic [WIDTH:0]   cnt_x_s;
    logic [WIDTH:0]   limit_x_s;
    logic             cfg_cond_s;
    logic             aligned_s;
    logic [WIDTH:0]   delta_s;
    logic [WIDTH-1:0] low_s;
    logic [WIDTH-1:0] high_s;
    logic [WIDTH:0]   cand_up_s;
    logic [WIDTH:0]   cand_dn_s;
    logic             pp_dir_s;
    logic [WIDTH:0]   pp_next_s;

    assign cnt_x_s    = {1'b0, cnt_q};
    assign limit_x_s  = {1'b0, limit};
    assign cfg_cond_s = en & (mode == MODE_ODD) & (limit == {WIDTH{1'b0}});

    // Mode-dependent step, low bound, high aligned value and candidates.
    always_comb begin
        aligned_s = 1'b1;
        delta_s   = ONE_X;
        low_s     = {WIDTH{1'b0}};
        high_s    = limit;
        case (mode)
            MODE_EVEN: begin
                aligned_s = (cnt_q[0] == 1'b0);
                delta_s   = aligned_s ? TWO_X : ONE_X;
                low_s     = {WIDTH{1'b0}};
                high_s    = {limit[WIDTH-1:1], 1'b0};
            end
            MODE_ODD: begin
                aligned_s = (cnt_q[0] == 1'b1);
                delta_s   = aligned_s ? TWO_X : ONE_X;
                low_s     = {{(WIDTH-1){1'b0}}, 1'b1};
                // limit==0 cannot reach here while enabled (cfg_err holds cnt)
                high_s    = limit[0] ? limit : (limit - {{(WIDTH-1){1'b0}}, 1'b1});
            end
            MODE_ALL: begin
                aligned_s = 1'b1;
                delta_s   = ONE_X;
                low_s     = {WIDTH{1'b0}};
                high_s    = limit;
            end
            default: begin
                aligned_s = 1'b1;
                delta_s   = ONE_X;
                low_s     = {WIDTH{1'b0}};
                high_s    = limit;
            end
        endcase
        cand_up_s = cnt_x_s + delta_s;
        cand_dn_s = cnt_x_s - delta_s;
    end

    // Ping-pong effective direction: turn around when already parked on an end.
    always_comb begin
        pp_dir_s = dir_q;
        if ((dir_q == DIR_UP) && (cnt_q == limit)) begin
            pp_dir_s = DIR_DOWN;
        end else if ((dir_q == DIR_DOWN) && (cnt_q == {WIDTH{1'b0}})) begin
            pp_dir_s = DIR_UP;
        end else begin
            pp_dir_s = dir_q;
        end
        pp_next_s = (pp_dir_s == DIR_DOWN) ? (cnt_x_s - ONE_X) : (cnt_x_s + ONE_X);
    end

    // Next-state selection with priority load > enable (reset handled in the register).
    always_comb begin
        cnt_d     = cnt_q;
        wrap_d    = 1'b0;
        dir_d     = dir_q;
        cfg_err_d = cfg_cond_s;
        if (load) begin
            cnt_d = load_val;
            dir_d = DIR_UP;
        end else if (!en || cfg_cond_s) begin
            cnt_d = cnt_q;
        end else if (mode != MODE_PP) begin
            if (dir == DIR_UP) begin
                if (cand_up_s > limit_x_s) begin
                    cnt_d  = low_s;
                    wrap_d = 1'b1;
                end else begin
                    cnt_d  = cand_up_s[WIDTH-1:0];
                end
            end else begin
                // cand_dn_s[WIDTH] set means the subtraction went below zero
                if (cand_dn_s[WIDTH] || (cand_dn_s < {1'b0, low_s}) || (cnt_q > limit)) begin
                    cnt_d  = high_s;
                    wrap_d = 1'b1;
                end else begin
                    cnt_d  = cand_dn_s[WIDTH-1:0];
                end
            end
        end else begin
            if (cnt_q > limit) begin
                cnt_d  = limit;
                dir_d  = DIR_DOWN;
                wrap_d = 1'b1;
            end else if (limit == {WIDTH{1'b0}}) begin
                cnt_d  = cnt_q;
            end else begin
                cnt_d = pp_next_s[WIDTH-1:0];
                dir_d = pp_dir_s;
                if ((pp_dir_s == DIR_UP) && (pp_next_s == limit_x_s)) begin
                    wrap_d = 1'b1;
                    dir_d  = DIR_DOWN;
                end else if ((pp_dir_s == DIR_DOWN) && (pp_next_s == {(WIDTH+1){1'b0}})) begin
                    wrap_d = 1'b1;
                    dir_d  = DIR_UP;
                end else begin
                    wrap_d = 1'b0;
                end
            end
        end
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= RST_VAL;
            wrap_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            dir_q     <= DIR_UP;
        end else begin
            cnt_q     <= cnt_d;
            wrap_q    <= wrap_d;
            cfg_err_q <= cfg_err_d;
            dir_q     <= dir_d;
        end
    end

    assign cnt     = cnt_q;
    assign wrap    = wrap_q;
    assign cfg_err = cfg_err_q;

endmodule
